// File: rtl/gp_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gp_write_arbiter
// Description : Round-robin arbiter sharing the GPR file write port between
//               NUM_UNITS execution units. The winner is held for one cycle
//               in an output stage where a register-file read port confirms
//               the target register still waits for this producer; stale
//               results are dropped silently.
//               Optional statistics counters: GP_WRITE_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_write_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_UNITS-1:0]   req_valid,
    input  logic [4:0]             req_addr  [NUM_UNITS],
    input  logic [31:0]            req_value [NUM_UNITS],
    input  logic [RS_ID_WIDTH-1:0] req_rs_id [NUM_UNITS],
    output logic [NUM_UNITS-1:0]   req_ready,
    output logic [4:0]             chk_addr,
    input  logic                   chk_value_valid,
    input  logic [RS_ID_WIDTH-1:0] chk_rs_id,
    output logic [4:0]             write_addr,
    output logic                   write_enable,
    output logic [31:0]            write_value
`ifdef GP_WRITE_ARB_STATS_EN
    ,
    output logic [31:0]            stat_grants,
    output logic [31:0]            stat_drops
`endif
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    logic [PTR_W-1:0]       r_rr_ptr;
    logic                   r_stage_valid;
    logic [4:0]             r_stage_addr;
    logic [31:0]            r_stage_value;
    logic [RS_ID_WIDTH-1:0] r_stage_rs_id;

    logic                   w_found;
    logic [PTR_W-1:0]       w_idx;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_xfer;
    logic                   w_write_enable;

    // Reduce a search offset to a unit index (wraps for non-power-of-two counts)
    function automatic logic [PTR_W-1:0] f_wrap(input int v);
        return PTR_W'(v % NUM_UNITS);
    endfunction

    // Round-robin search: first valid unit at or above the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!w_found && req_valid[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_found = 1'b1;
                w_idx   = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    // One-hot grant; forced low while reset is asserted
    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_ready
            assign req_ready[u] = rst_n & w_found & (w_idx == PTR_W'(u));
        end
    endgenerate

    assign w_xfer     = |(req_valid & req_ready);
    assign w_next_ptr = (w_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : w_idx + PTR_W'(1);

    // Output stage and pointer; stage payload only reloads on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_stage_valid <= 1'b0;
            r_stage_addr  <= '0;
            r_stage_value <= '0;
            r_stage_rs_id <= '0;
        end else begin
            r_stage_valid <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr      <= w_next_ptr;
                r_stage_addr  <= req_addr[w_idx];
                r_stage_value <= req_value[w_idx];
                r_stage_rs_id <= req_rs_id[w_idx];
            end
        end
    end

    // Stale check: write only if the register is still pending on this producer
    assign w_write_enable = r_stage_valid & ~chk_value_valid & (chk_rs_id == r_stage_rs_id);

    assign chk_addr     = r_stage_addr;
    assign write_addr   = r_stage_addr;
    assign write_value  = r_stage_value;
    assign write_enable = w_write_enable;

`ifdef GP_WRITE_ARB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_drops;

    // Free-running wrap-around counters of accepted requests and dropped results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_grants <= '0;
            r_stat_drops  <= '0;
        end else begin
            if (w_xfer) begin
                r_stat_grants <= r_stat_grants + 32'd1;
            end
            if (r_stage_valid && !w_write_enable) begin
                r_stat_drops <= r_stat_drops + 32'd1;
            end
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_drops  = r_stat_drops;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gp_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_write_arbiter
// Description : Self-checking bench for gp_write_arbiter. A register-file
//               model answers the check read port; a reference model tracks
//               the round-robin order, the output stage and the counters.
//               Statistics checks are compiled with GP_WRITE_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_write_arbiter;

    localparam int NUM = 4;
    localparam int RSW = 5;

    logic            clk;
    logic            rst_n;
    logic [NUM-1:0]  req_valid;
    logic [4:0]      req_addr  [NUM];
    logic [31:0]     req_value [NUM];
    logic [RSW-1:0]  req_rs_id [NUM];
    logic [NUM-1:0]  req_ready;
    logic [4:0]      chk_addr;
    logic            chk_value_valid;
    logic [RSW-1:0]  chk_rs_id;
    logic [4:0]      write_addr;
    logic            write_enable;
    logic [31:0]     write_value;
`ifdef GP_WRITE_ARB_STATS_EN
    logic [31:0]     stat_grants;
    logic [31:0]     stat_drops;
`endif

    // Register-file model: valid bit and producer ID per GPR
    logic            rf_valid [32];
    logic [RSW-1:0]  rf_rs    [32];

    assign chk_value_valid = rf_valid[chk_addr];
    assign chk_rs_id       = rf_rs[chk_addr];

    gp_write_arbiter #(.NUM_UNITS(NUM), .RS_ID_WIDTH(RSW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_value       (req_value),
        .req_rs_id       (req_rs_id),
        .req_ready       (req_ready),
        .chk_addr        (chk_addr),
        .chk_value_valid (chk_value_valid),
        .chk_rs_id       (chk_rs_id),
        .write_addr      (write_addr),
        .write_enable    (write_enable),
        .write_value     (write_value)
`ifdef GP_WRITE_ARB_STATS_EN
        ,
        .stat_grants     (stat_grants),
        .stat_drops      (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    bit              m_sv;
    logic [4:0]      m_sa;
    logic [31:0]     m_sval;
    logic [RSW-1:0]  m_srs;
    logic [31:0]     m_grants;
    logic [31:0]     m_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_sv     = 0;
        m_sa     = '0;
        m_sval   = '0;
        m_srs    = '0;
        m_grants = '0;
        m_drops  = '0;
    endtask

    // Winner: first valid unit scanning upward from the pointer, wrapping
    function automatic int model_grant();
        for (int i = 0; i < NUM; i++) begin
            if (req_valid[(m_ptr + i) % NUM]) return (m_ptr + i) % NUM;
        end
        return -1;
    endfunction

    task automatic clear_reqs();
        req_valid = '0;
        for (int u = 0; u < NUM; u++) begin
            req_addr[u]  = '0;
            req_value[u] = '0;
            req_rs_id[u] = '0;
        end
    endtask

    // One cycle: called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic step(input string tag);
        int         g;
        bit         exp_we;
        logic [NUM-1:0] exp_ready;
        #1;
        g         = model_grant();
        exp_ready = (g >= 0) ? NUM'(1 << g) : '0;
        exp_we    = m_sv && !rf_valid[m_sa] && (rf_rs[m_sa] == m_srs);
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        check({tag, ".we"}, 32'(write_enable), 32'(exp_we));
        if (m_sv) check({tag, ".chk_addr"}, 32'(chk_addr), 32'(m_sa));
        if (exp_we) begin
            check({tag, ".waddr"}, 32'(write_addr), 32'(m_sa));
            check({tag, ".wval"}, write_value, m_sval);
        end
`ifdef GP_WRITE_ARB_STATS_EN
        check({tag, ".grants"}, stat_grants, m_grants);
        check({tag, ".drops"}, stat_drops, m_drops);
`endif
        // Commit the cycle in the model
        if (exp_we) rf_valid[m_sa] = 1'b1;
        if (m_sv && !exp_we) m_drops = m_drops + 32'd1;
        if (g >= 0) begin
            m_ptr    = (g + 1) % NUM;
            m_sv     = 1;
            m_sa     = req_addr[g];
            m_sval   = req_value[g];
            m_srs    = req_rs_id[g];
            m_grants = m_grants + 32'd1;
        end else begin
            m_sv = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf_valid[r] = 1'b1;
            rf_rs[r]    = '0;
        end
        clear_reqs();
        model_reset();
        rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        check("reset.ready", 32'(req_ready), 32'h0);
        check("reset.we", 32'(write_enable), 32'h0);
        check("reset.chk_addr", 32'(chk_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_reqs();

        // Single request from unit 2 to a pending register
        rf_valid[7] = 1'b0; rf_rs[7] = 5'd3;
        req_valid[2] = 1'b1; req_addr[2] = 5'd7; req_value[2] = 32'hDEADBEEF; req_rs_id[2] = 5'd3;
        step("single0");
        clear_reqs();
        step("single1");

        // Fairness: all units valid, distinct pending registers
        for (int u = 0; u < NUM; u++) begin
            req_valid[u] = 1'b1;
            req_addr[u]  = 5'(10 + u);
            req_rs_id[u] = 5'(u + 1);
        end
        for (int c = 0; c < 8; c++) begin
            for (int u = 0; u < NUM; u++) begin
                rf_valid[10 + u] = 1'b0;
                rf_rs[10 + u]    = 5'(u + 1);
                req_value[u]     = $urandom;
            end
            step("fair");
        end
        clear_reqs();
        step("fair_end");

        // Stale by rs_id
        rf_valid[5] = 1'b0; rf_rs[5] = 5'd9;
        req_valid[1] = 1'b1; req_addr[1] = 5'd5; req_value[1] = 32'h1234_5678; req_rs_id[1] = 5'd4;
        step("stale_id0");
        clear_reqs();
        step("stale_id1");

        // Stale by valid: register already valid with matching ID
        rf_valid[9] = 1'b1; rf_rs[9] = 5'd6;
        req_valid[3] = 1'b1; req_addr[3] = 5'd9; req_value[3] = 32'hCAFE_0001; req_rs_id[3] = 5'd6;
        step("stale_v0");
        clear_reqs();
        step("stale_v1");

        // Rename after acceptance makes the staged result stale
        rf_valid[12] = 1'b0; rf_rs[12] = 5'd2;
        req_valid[0] = 1'b1; req_addr[0] = 5'd12; req_value[0] = 32'hBEEF_0002; req_rs_id[0] = 5'd2;
        step("rename0");
        clear_reqs();
        rf_rs[12] = 5'd17;
        step("rename1");

        // Reset while the stage holds a result
        for (int u = 0; u < NUM; u++) begin
            req_valid[u] = 1'b1; req_addr[u] = 5'(20 + u); req_rs_id[u] = 5'd1;
            rf_valid[20 + u] = 1'b0; rf_rs[20 + u] = 5'd1;
        end
        step("mid0");
        step("mid1");
        rst_n = 1'b0;
        #1;
        check("mid_rst.we", 32'(write_enable), 32'h0);
        check("mid_rst.chk_addr", 32'(chk_addr), 32'h0);
        check("mid_rst.ready", 32'(req_ready), 32'h0);
        model_reset();
`ifdef GP_WRITE_ARB_STATS_EN
        check("mid_rst.grants", stat_grants, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst0");
        step("after_rst1");
        clear_reqs();
        step("after_rst2");

`ifdef GP_WRITE_ARB_STATS_EN
        // Grant counter wraps to zero
        force dut.r_stat_grants = 32'hFFFF_FFFF;
        #1;
        release dut.r_stat_grants;
        m_grants = 32'hFFFF_FFFF;
        req_valid[1] = 1'b1;
        step("wrap0");
        clear_reqs();
        step("wrap1");
`endif

        // Randomized traffic with a churning register file
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < NUM; u++) begin
                req_valid[u] = ($urandom_range(0, 2) != 0);
                req_addr[u]  = 5'($urandom_range(0, 31));
                req_value[u] = $urandom;
                req_rs_id[u] = RSW'($urandom_range(0, 3));
            end
            for (int k = 0; k < 3; k++) begin
                int r;
                r = $urandom_range(0, 31);
                rf_valid[r] = ($urandom_range(0, 3) == 0);
                rf_rs[r]    = RSW'($urandom_range(0, 3));
            end
            step("rand");
        end
        clear_reqs();
        step("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gp_write_arbiter.md
# gp_write_arbiter

Shares the single write port of the general-purpose register file between `NUM_UNITS` execution units that complete results in the same cycle. Grants one requester per cycle round-robin, holds the grant for one cycle in an output stage, and checks there, against a register-file read port, that the target register is still waiting for that result. Results already superseded by a newer rename are dropped, so a late unit cannot overwrite the value of a younger instruction. Sits between the execution units' result buses and the register file's write port and one of its read ports.

## Interface
- `NUM_UNITS`, 4: number of requesting execution units, 2..16.
- `RS_ID_WIDTH`, 5: reservation-station ID width; matches the register file.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[0:NUM_UNITS-1]`  in  1 each  unit holds a result.
- `req_addr[0:NUM_UNITS-1]`  in  5 each  destination GPR.
- `req_value[0:NUM_UNITS-1]`  in  32 each  result value.
- `req_rs_id[0:NUM_UNITS-1]`  in  RS_ID_WIDTH each  ID of the producing reservation station.
- `req_ready[0:NUM_UNITS-1]`  out  1 each  grant; the transfer happens when `req_valid` and `req_ready` are both high.
- `chk_addr`  out  5  register-file read-port address, driven from the stage.
- `chk_value_valid`  in  1  read-port valid bit, combinational from the register file.
- `chk_rs_id`  in  RS_ID_WIDTH  read-port RS ID, combinational from the register file.
- `write_addr`  out  5  register-file write address.
- `write_enable`  out  1  register-file write enable.
- `write_value`  out  32  register-file write data.
- `stat_grants`  out  32  count of accepted requests; present only with `GP_WRITE_ARB_STATS_EN`.
- `stat_drops`  out  32  count of stale results dropped; present only with `GP_WRITE_ARB_STATS_EN`.

## Operation
- **Arbitration (combinational)**
  - Search order starts at `rr_ptr` and proceeds upward, wrapping modulo `NUM_UNITS`.
  - The first unit with `req_valid` high gets `req_ready` high. All other `req_ready` stay low.
  - `req_ready` never depends on `req_ready`. It may depend on `req_valid`.
- **Pointer update**
  - On a grant to unit k: `rr_ptr <= (k+1) mod NUM_UNITS`.
  - With no grant, `rr_ptr` holds.
- **Stage**
  - Each cycle the stage loads `stage_valid <= |(req_valid & req_ready)`, together with the granted unit's addr, value and rs_id.
  - The stage never back-pressures. Throughput is 1 result per cycle.
- **Stale check**
  - `chk_addr = stage_addr` at all times.
  - `write_enable = stage_valid & ~chk_value_valid & (chk_rs_id == stage_rs_id)`.
  - `write_addr = stage_addr`, `write_value = stage_value`.
- **Drop**
  - A drop is `stage_valid & ~write_enable`.
  - The result is discarded silently. The requester was already acknowledged.
- **Reset** (asynchronous, immediate, mid-operation included)
  - `rr_ptr = 0`, `stage_valid = 0`, stage addr/value/rs_id = 0.
  - Hence `write_enable = 0` and `chk_addr = 0`.
  - Any in-flight stage content is lost.
  - `req_ready` = 0 while `rst_n` is low.

## Timing
- Accepted in cycle N → `write_enable` high in cycle N+1 → register-file content updated at the end of N+1.
- The stale check uses register-file state as of cycle N+1. An `update_enable` to the same register committed at the end of cycle N makes the result stale, and it is dropped.
- The register file's own same-cycle update/write priority (update wins on the valid bit) is untouched by this block.
- Back-to-back grants are allowed every cycle. With K units continuously valid, each unit is granted once every K cycles, never waiting more than `NUM_UNITS-1` cycles.

## Configuration
- `GP_WRITE_ARB_STATS_EN` defined:
  - `stat_grants` increments on every accepted request.
  - `stat_drops` increments on every drop.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Not defined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- Single request: unit 2 valid, addr 7, value 0xDEADBEEF, rs_id 3; register 7 invalid with rs_id 3 → `req_ready[2]` high in cycle 0; in cycle 1 `write_enable`=1, `write_addr`=7, `write_value`=0xDEADBEEF.
- Fairness: all 4 units continuously valid from reset → grant order 0,1,2,3,0,1,… with no gaps and one write per cycle.
- Stale by rs_id: unit 1 writes addr 5, rs_id 4, while register 5 holds rs_id 9 → acknowledged, `write_enable`=0 in cycle N+1, `stat_drops` +1.
- Stale by valid: register already valid with a matching rs_id → dropped. Rename in cycle N to another ID → the next-cycle write is dropped.
- Reset mid-flight: `rst_n` low while `stage_valid`=1 → `write_enable` drops immediately, `rr_ptr`=0. After release, unit 0 is granted first.
- Stats wrap: with the macro defined, force `stat_grants`=0xFFFFFFFF, then one grant → reads 0.
